ram_fifo_ctrl: RTL and testbench

//   FIFO controller sitting directly upstream of the 64x32 single-port ram block.

---
 rtl/ram_fifo_ctrl_if.sv | 23 ++
 rtl/ram_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for ram_fifo_ctrl.
// master drives push/pop and wdata; slave (the controller) answers with ready and read data.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              push;
    logic [DATA_W-1:0] wdata;
    logic              push_ready;
    logic              pop;
    logic              pop_ready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output push, wdata, pop,
        input  push_ready, pop_ready, rdata, rvalid
    );

    modport slave (
        input  push, wdata, pop,
        output push_ready, pop_ready, rdata, rvalid
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port 64x32 ram; pop wins the port over push.
// Optional sticky overflow/underflow flags under FIFO_ERR_FLAGS_EN (ports tied to 0 otherwise).
module ram_fifo_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_fifo_ctrl_if.slave    fif,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ovf_err,
    output logic              udf_err
);
    localparam int            STAGES = 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

    typedef struct packed {
        logic              cen;
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } ram_req_t;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   cnt_q;
    logic [STAGES:1]   vld_pipe;
    logic              pop_acc, push_acc;
    ram_req_t          req;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH);
    assign count = cnt_q;

    assign pop_acc        = fif.pop && !empty;
    assign push_acc       = fif.push && !full && !pop_acc;
    assign fif.pop_ready  = !empty;
    assign fif.push_ready = !full && !pop_acc;

    // Port is idle-zero when nothing is accepted so ram dout reads back 0.
    always_comb begin
        req = '0;
        if (pop_acc) begin
            req.cen  = 1'b1;
            req.addr = rd_ptr;
        end else if (push_acc) begin
            req.cen  = 1'b1;
            req.wen  = 1'b1;
            req.addr = wr_ptr;
            req.din  = fif.wdata;
        end
    end

    assign ram_cen  = req.cen;
    assign ram_wen  = req.wen;
    assign ram_addr = req.addr;
    assign ram_din  = req.din;

    // Pointers wrap naturally at ADDR_W bits; count needs the extra bit to reach DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= STAGES'({vld_pipe, pop_acc});
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt_q  <= cnt_q - 1'b1;
            end else if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    assign fif.rvalid = vld_pipe[STAGES];
    assign fif.rdata  = fif.rvalid ? ram_dout : '0;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (fif.push && full) ovf_q <= 1'b1;
            if (fif.pop && empty) udf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 64x32 registered-output ram and a read-data scoreboard.
module tb_ram_fifo_ctrl;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          empty, full;
    logic [AW:0]   count;
    logic          ram_cen, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic          ovf_err, udf_err;

    ram_fifo_ctrl_if #(.DATA_W(DW)) fif ();

    ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .fif      (fif),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .ram_cen  (ram_cen),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_cen && ram_wen) mem[ram_addr] <= ram_din;
        ram_dout <= (ram_cen && !ram_wen) ? mem[ram_addr] : '0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    int            mcnt = 0;
    logic [AW-1:0] mwp = '0, mrp = '0;
    logic          movf = 1'b0, mudf = 1'b0;

    // One clock of stimulus: check combinational ram/handshake outputs, then post-edge state.
    task automatic cyc(input logic ps, input logic [DW-1:0] wd, input logic pp, input logic rn);
        logic e_pop, e_push;
        logic [AW-1:0] e_addr;
        fif.push = ps; fif.wdata = wd; fif.pop = pp; reset_n = rn;
        #2;
        e_pop  = pp && mcnt != 0;
        e_push = ps && mcnt != DEPTH && !e_pop;
        e_addr = e_pop ? mrp : (e_push ? mwp : '0);
        if (rn) begin
            chk("pop_ready", fif.pop_ready, mcnt != 0);
            chk("push_ready", fif.push_ready, mcnt != DEPTH && !e_pop);
            chk("ram_cen", ram_cen, e_pop || e_push);
            chk("ram_wen", ram_wen, e_push);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_din", ram_din, e_push ? wd : '0);
        end
        @(posedge clk); #1;
        if (!rn) begin
            mq.delete(); exp_q.delete();
            mcnt = 0; mwp = '0; mrp = '0; movf = 1'b0; mudf = 1'b0;
        end else begin
            if (ps && mcnt == DEPTH) movf = FLAGS;
            if (pp && mcnt == 0) mudf = FLAGS;
            if (e_pop) begin
                exp_q.push_back(mq.pop_front());
                mrp++; mcnt--;
            end else if (e_push) begin
                mq.push_back(wd);
                mwp++; mcnt++;
            end
        end
        chk("rvalid", fif.rvalid, exp_q.size() != 0);
        if (fif.rvalid && exp_q.size() != 0) chk("rdata", fif.rdata, exp_q.pop_front());
        else if (!fif.rvalid) chk("rdata_idle", fif.rdata, '0);
        chk("count", count, mcnt);
        chk("empty", empty, mcnt == 0);
        chk("full", full, mcnt == DEPTH);
        chk("ovf_err", ovf_err, movf);
        chk("udf_err", udf_err, mudf);
    endtask

    initial begin
        fif.push = 1'b0; fif.pop = 1'b0; fif.wdata = '0; reset_n = 1'b0;
        @(posedge clk); #1;
        // T1 reset
        cyc(0, '0, 0, 0);
        chk("t1_count", count, 0);
        chk("t1_empty", empty, 1);
        cyc(0, '0, 0, 1);
        chk("t1_cen_idle", ram_cen, 0);
        // T2 write then back-to-back reads
        cyc(1, 32'hA5A5_0001, 0, 1);
        cyc(1, 32'hA5A5_0002, 0, 1);
        chk("t2_count2", count, 2);
        cyc(0, '0, 1, 1);
        chk("t2_rd1", fif.rdata, 32'hA5A5_0001);
        cyc(0, '0, 1, 1);
        chk("t2_rd2", fif.rdata, 32'hA5A5_0002);
        cyc(0, '0, 0, 1);
        chk("t2_count0", count, 0);
        // T3 fill to full, then one extra push
        for (int i = 0; i < DEPTH; i++) cyc(1, DW'(i), 0, 1);
        chk("t3_full", full, 1);
        chk("t3_count", count, 64);
        cyc(1, 32'hDEAD_BEEF, 0, 1);
        chk("t3_count_hold", count, 64);
        chk("t3_ovf", ovf_err, FLAGS);
        // T4 wrap: pop 10, push 10 into slots 0..9, then drain
        for (int i = 0; i < 10; i++) cyc(0, '0, 1, 1);
        for (int i = 0; i < 10; i++) cyc(1, 32'h100 + DW'(i), 0, 1);
        for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1, 1);
        cyc(0, '0, 0, 1);
        chk("t4_empty", empty, 1);
        // T5 contention with three entries
        cyc(0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h200 + DW'(i), 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 32'h3000_0000, 1, 1);
        chk("t5_count0", count, 0);
        cyc(1, 32'h3000_0000, 1, 1);
        chk("t5_count1", count, 1);
        cyc(0, '0, 1, 1);
        chk("t5_rd", fif.rdata, 32'h3000_0000);
        // T6 reset right after a pop accept, then underflow
        cyc(1, 32'h4444_0000, 0, 1);
        cyc(0, '0, 1, 1);
        cyc(0, '0, 0, 0);
        chk("t6_rvalid", fif.rvalid, 0);
        chk("t6_count", count, 0);
        cyc(0, '0, 1, 1);
        chk("t6_udf", udf_err, FLAGS);
        cyc(0, '0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
